// File: rtl/high_pass_exp_pkg.sv
// Shared definitions for the exponential filter family: FSM state encoding
// and accumulator width helper.
package high_pass_exp_pkg;

  // Four-step sample sequence: accept, difference, multiply, accumulate.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIFF = 2'd1,
    ST_MULT = 2'd2,
    ST_ACC  = 2'd3
  } state_t;

  // Accumulator holds the integer part (sample width) plus the alpha fraction.
  function automatic int acc_width(input int width, input int alpha_width);
    return width + alpha_width;
  endfunction

endpackage

// File: rtl/hp_exp_datapath.sv
// Datapath of the exponential high-pass filter: sample/alpha capture,
// e = x - y_hi, p = e * alpha, y_acc += p, and output saturation.
// Every stage owns one register so the multiply can sit in a DSP with its
// pipeline register.
module hp_exp_datapath
  import high_pass_exp_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ALPHA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_en_i,
  input  logic                    diff_en_i,
  input  logic                    mult_en_i,
  input  logic                    acc_en_i,
  input  logic signed [WIDTH-1:0] data_i,
  input  logic [ALPHA_WIDTH-1:0]  alpha_i,
  output logic signed [WIDTH-1:0] data_o,
  output logic                    valid_o
);

  localparam int ACC_W = acc_width(WIDTH, ALPHA_WIDTH);
  localparam int E_W   = WIDTH + 1;
  localparam int P_W   = WIDTH + ALPHA_WIDTH + 2;

  logic signed [WIDTH-1:0] x_reg;
  logic [ALPHA_WIDTH-1:0]  a_reg;
  logic signed [E_W-1:0]   e_reg;
  logic signed [P_W-1:0]   p_reg;
  logic signed [ACC_W-1:0] y_acc_reg;
  logic signed [WIDTH-1:0] data_reg;
  logic                    valid_reg;

  logic signed [WIDTH-1:0] y_hi;
  logic signed [E_W-1:0]   e_next;
  logic signed [P_W-1:0]   p_next;
  logic signed [ACC_W-1:0] y_acc_next;
  logic signed [WIDTH-1:0] sat_e;

  // Integer part of the estimate; bit slicing gives floor toward -inf.
  assign y_hi = y_acc_reg[ACC_W-1:ALPHA_WIDTH];

  // The product never exceeds ACC_W bits in magnitude once added (alpha < 1),
  // so its top bits are only carried for exactness.
  wire unused_p_hi = ^p_reg[P_W-1:ACC_W];

  // Stage arithmetic and the saturator for the high-pass output.
  always_comb begin
    e_next     = $signed({x_reg[WIDTH-1], x_reg}) - $signed({y_hi[WIDTH-1], y_hi});
    p_next     = P_W'(e_reg) * P_W'($signed({1'b0, a_reg}));
    y_acc_next = y_acc_reg + $signed(p_reg[ACC_W-1:0]);
    sat_e      = e_reg[WIDTH-1:0];
    if (e_reg[E_W-1] != e_reg[E_W-2]) begin
      sat_e = e_reg[E_W-1] ? $signed({1'b1, {(WIDTH-1){1'b0}}})
                           : $signed({1'b0, {(WIDTH-1){1'b1}}});
    end
  end

  // Stage registers, each advanced only by its FSM step enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_reg     <= '0;
      a_reg     <= '0;
      e_reg     <= '0;
      p_reg     <= '0;
      y_acc_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (load_en_i) begin
        x_reg <= data_i;
        a_reg <= alpha_i;
      end
      if (diff_en_i) e_reg <= e_next;
      if (mult_en_i) p_reg <= p_next;
      if (acc_en_i) begin
        y_acc_reg <= y_acc_next;
        data_reg  <= sat_e;
        valid_reg <= 1'b1;
      end
    end
  end

  assign data_o  = data_reg;
  assign valid_o = valid_reg;

endmodule

// File: rtl/high_pass_exp.sv
// Exponential (first-order IIR) high-pass filter. Outputs h = x - y_old while
// tracking y += alpha*(x - y). Accepts one strobed sample per 4 clocks; samples
// offered while busy are dropped and counted.
module high_pass_exp
  import high_pass_exp_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int alpha_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [WIDTH-1:0] data_i,
  input  logic                    valid_i,
  input  logic [alpha_WIDTH-1:0]  alpha_i,
  input  logic                    clr_i,
  output logic signed [WIDTH-1:0] data_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic [CNT_WIDTH-1:0]    drop_cnt_o
);

  state_t state_reg, state_next;
  logic   load_en, diff_en, mult_en, acc_en;
  logic   drop;
  logic                 overrun_reg;
  logic [CNT_WIDTH-1:0] drop_cnt_reg;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next state and per-step datapath enables.
  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    diff_en    = 1'b0;
    mult_en    = 1'b0;
    acc_en     = 1'b0;
    case (state_reg)
      ST_IDLE: if (valid_i) begin
        load_en    = 1'b1;
        state_next = ST_DIFF;
      end
      ST_DIFF: begin
        diff_en    = 1'b1;
        state_next = ST_MULT;
      end
      ST_MULT: begin
        mult_en    = 1'b1;
        state_next = ST_ACC;
      end
      ST_ACC: begin
        acc_en     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_o = (state_reg != ST_IDLE);
  assign drop   = valid_i && busy_o;

  // Sticky overrun flag and saturating drop counter; a drop outranks a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      overrun_reg <= 1'b1;
      if (clr_i)               drop_cnt_reg <= CNT_WIDTH'(1);
      else if (~&drop_cnt_reg) drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
    end else if (clr_i) begin
      overrun_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end
  end

  assign overrun_o  = overrun_reg;
  assign drop_cnt_o = drop_cnt_reg;

  hp_exp_datapath #(
    .WIDTH       (WIDTH),
    .ALPHA_WIDTH (alpha_WIDTH)
  ) u_datapath (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_en_i (load_en),
    .diff_en_i (diff_en),
    .mult_en_i (mult_en),
    .acc_en_i  (acc_en),
    .data_i    (data_i),
    .alpha_i   (alpha_i),
    .data_o    (data_o),
    .valid_o   (valid_o)
  );

endmodule

// File: tb/tb_high_pass_exp.sv
// Scoreboard bench for high_pass_exp: expected outputs and their due edge are
// queued when a sample is offered and checked when valid_o pulses.
module tb_high_pass_exp;

  localparam int WIDTH = 16;
  localparam int AW    = 32;
  localparam int CW    = 16;

  logic                    clk_i   = 1'b0;
  logic                    rst_i   = 1'b1;
  logic signed [WIDTH-1:0] data_i  = '0;
  logic                    valid_i = 1'b0;
  logic [AW-1:0]           alpha_i = '0;
  logic                    clr_i   = 1'b0;
  logic signed [WIDTH-1:0] data_o;
  logic                    valid_o;
  logic                    busy_o;
  logic                    overrun_o;
  logic [CW-1:0]           drop_cnt_o;

  high_pass_exp #(.WIDTH(WIDTH), .alpha_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .alpha_i    (alpha_i),
    .clr_i      (clr_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic signed [WIDTH-1:0] data;
    int                      edge_n;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   vcount = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Output monitor: every valid_o pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      vcount++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: valid_o=1 data_o=%0d at edge %0d, required no output", data_o, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        $display("txn: edge=%0d data_o=%0d (expected %0d at edge %0d)", cyc, data_o, mon_e.data, mon_e.edge_n);
        if (data_o !== mon_e.data) begin
          errors++;
          $display("FAIL data_o: got %0d, required %0d", data_o, mon_e.data);
        end
        checks++;
        if (cyc !== mon_e.edge_n) begin
          errors++;
          $display("FAIL latency: valid_o at edge %0d, required edge %0d", cyc, mon_e.edge_n);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i   = 1'b1;
    valid_i = 1'b0;
    clr_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    sb_q.delete();
  endtask

  // Offer one sample from an idle DUT; returns at the negedge after acceptance.
  task automatic send(input logic signed [WIDTH-1:0] x, input logic [AW-1:0] a,
                      input logic signed [WIDTH-1:0] expd);
    exp_t t;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL send_busy: busy_o=%b before offering x=%0d, required 0", busy_o, x);
    end
    valid_i  = 1'b1;
    data_i   = x;
    alpha_i  = a;
    t.data   = expd;
    t.edge_n = cyc + 1 + 3;
    sb_q.push_back(t);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  // Three more negedges so the next send lands on accept edge + 4.
  task automatic gap();
    repeat (3) @(negedge clk_i);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (20) @(negedge clk_i);
    checks++;
    if (data_o !== 16'sd0) begin errors++; $display("FAIL reset_data: got %0d, required 0", data_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    checks++;
    if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt_o); end
    checks++;
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun_o); end
  endtask

  task automatic test_alpha_zero();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(16'sd1000, 32'h0, 16'sd1000);
      gap();
    end
    wait_drain();
  endtask

  // alpha = 1/2 from y=0: y goes 500, 750, 875, 937.5; floor(937.5)=937 so
  // the fifth output is 1000-937 = 63.
  task automatic test_alpha_half();
    logic signed [WIDTH-1:0] seq [5];
    seq = '{16'sd1000, 16'sd500, 16'sd250, 16'sd125, 16'sd63};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(16'sd1000, 32'h8000_0000, seq[i]);
      gap();
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    do_reset();
    send(-16'sd32768, 32'hFFFF_FFFF, -16'sd32768);
    gap();
    send(16'sd32767, 32'hFFFF_FFFF, 16'sd32767);
    gap();
    send(-16'sd32768, 32'hFFFF_FFFF, -16'sd32768);
    wait_drain();
  endtask

  task automatic test_overrun();
    exp_t t;
    do_reset();
    valid_i  = 1'b1;
    data_i   = 16'sd300;
    alpha_i  = 32'h0;
    t.data   = 16'sd300;
    t.edge_n = cyc + 1 + 3;
    sb_q.push_back(t);
    repeat (4) @(negedge clk_i);
    valid_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, required 1", overrun_o); end
    checks++;
    if (drop_cnt_o !== 16'd3) begin errors++; $display("FAIL drop_cnt_3: got %0d, required 3", drop_cnt_o); end
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b, required 0", overrun_o); end
    checks++;
    if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL drop_cnt_clr: got %0d, required 0", drop_cnt_o); end
    wait_drain();
    send(16'sd200, 32'h0, 16'sd200);
    valid_i = 1'b1;
    clr_i   = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    clr_i   = 1'b0;
    checks++;
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL clr_drop_overrun: got %b, required 1", overrun_o); end
    checks++;
    if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL clr_drop_cnt: got %0d, required 1", drop_cnt_o); end
    wait_drain();
  endtask

  task automatic test_reset_mid_op();
    int v_before;
    do_reset();
    send(16'sd1000, 32'h8000_0000, 16'sd1000);
    wait_drain();
    v_before = vcount;
    valid_i = 1'b1;
    data_i  = 16'sd700;
    alpha_i = 32'h0;
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_op_busy: got %b, required 1", busy_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    checks++;
    if (vcount !== v_before) begin errors++; $display("FAIL aborted_valid: %0d pulses after abort, required 0", vcount - v_before); end
    checks++;
    if (data_o !== 16'sd0) begin errors++; $display("FAIL abort_data: got %0d, required 0", data_o); end
    send(16'sd500, 32'h0, 16'sd500);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_alpha_zero();
    test_alpha_half();
    test_saturation();
    test_overrun();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
